uart_8n1_rx_buffer: RTL and testbench

Downstream companion to the 8N1 UART receiver. It re-arms the receiver after every frame and captures each completed word. Error-free words go into a FIFO; errored words are dropped. Words leave through a first-word-fall-through valid/ready stream to the host logic. Runs entirely in the receiver's 16x-baud clock domain.

---
 rtl/uart_8n1_rx_buffer.sv | 129 ++++++++++++
 tb/tb_uart_8n1_rx_buffer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_8n1_rx_buffer.sv
// Re-arms an 8N1 receiver after every frame and buffers error-free words in a first-word-fall-through FIFO.
// Define UART_RX_BUFFER_ERR_COUNT_EN to build the saturating errored-frame counter; otherwise err_count is 0.
module uart_8n1_rx_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk_baud_16x,
    input  logic                reset_n,
    input  logic [7:0]          recv_data,
    input  logic                recv_busy,
    input  logic                recv_error,
    output logic                recv_read,
    output logic [7:0]          out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DEPTH_LOG2:0] count,
    output logic                overrun,
    input  logic                overrun_clear,
    output logic [7:0]          err_count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] PTR_ONE    = (DEPTH_LOG2 + 1)'(1);

    typedef enum logic [1:0] {
        ST_ARM,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t              state;
    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                pop;
    logic                push_req;
    logic                full;
    logic                push;
    logic                drop;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign count     = wr_ptr - rd_ptr;
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign full      = (count == FULL_COUNT);
    assign pop       = out_valid && out_ready;

    // The pop frees a slot before the full check, so a full FIFO still accepts a push alongside a pop.
    assign push_req  = (state == ST_DONE) && !recv_error;
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_baud_16x) begin
        if (!reset_n) begin
            state     <= ST_ARM;
            recv_read <= 1'b0;
        end else begin
            unique case (state)
                ST_ARM: begin
                    if (recv_busy) begin
                        state     <= ST_WAIT;
                        recv_read <= 1'b0;
                    end else begin
                        recv_read <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    recv_read <= 1'b0;
                    if (!recv_busy) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state     <= ST_ARM;
                    recv_read <= 1'b1;
                end
                default: begin
                    state     <= ST_ARM;
                    recv_read <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_baud_16x) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // NOTE: storage is deliberately left out of reset; emptiness is defined by the pointers alone.
    always_ff @(posedge clk_baud_16x) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= recv_data;
        end
    end

    always_ff @(posedge clk_baud_16x) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clear) begin
            overrun <= 1'b0;
        end
    end

`ifdef UART_RX_BUFFER_ERR_COUNT_EN
    always_ff @(posedge clk_baud_16x) begin
        if (!reset_n) begin
            err_count <= 8'h00;
        end else if ((state == ST_DONE) && recv_error && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'h01;
        end
    end
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_uart_8n1_rx_buffer.sv
// Self-checking bench for uart_8n1_rx_buffer: queue-based reference model plus directed literal checks.
module tb_uart_8n1_rx_buffer;

    localparam int DL    = 2;
    localparam int DEPTH = 4;
`ifdef UART_RX_BUFFER_ERR_COUNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk_baud_16x = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    recv_data = 8'h00;
    logic          recv_busy = 1'b0;
    logic          recv_error = 1'b0;
    logic          recv_read;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DL:0]   count;
    logic          overrun;
    logic          overrun_clear = 1'b0;
    logic [7:0]    err_count;

    int total = 0;
    int bad = 0;
    int frames_sent = 0;
    bit rand_on = 1'b0;

    always #5 clk_baud_16x = ~clk_baud_16x;

    uart_8n1_rx_buffer #(.DEPTH_LOG2(DL)) dut (
        .clk_baud_16x (clk_baud_16x),
        .reset_n      (reset_n),
        .recv_data    (recv_data),
        .recv_busy    (recv_busy),
        .recv_error   (recv_error),
        .recv_read    (recv_read),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .overrun      (overrun),
        .overrun_clear(overrun_clear),
        .err_count    (err_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue, the word lands one edge after the edge that sees busy fall.
    logic [7:0] q[$];
    bit         m_ovr = 1'b0;
    int         m_err = 0;
    bit         prev_busy = 1'b0;
    bit         done_pend = 1'b0;
    bit         started = 1'b0;
    bit         m_set;

    always @(posedge clk_baud_16x) begin
        if (!reset_n) begin
            q.delete();
            m_ovr = 1'b0;
            m_err = 0;
            prev_busy = 1'b0;
            done_pend = 1'b0;
            started = 1'b1;
        end else begin
            m_set = 1'b0;
            if (q.size() != 0 && out_ready) begin
                void'(q.pop_front());
            end
            if (done_pend) begin
                if (recv_error) begin
                    if (m_err < 255) m_err++;
                end else if (q.size() < DEPTH) begin
                    q.push_back(recv_data);
                end else begin
                    m_set = 1'b1;
                end
            end
            done_pend = prev_busy && !recv_busy;
            prev_busy = recv_busy;
            if (m_set) m_ovr = 1'b1;
            else if (overrun_clear) m_ovr = 1'b0;
        end
        if (started) begin
            #1;
            check("m_count", 32'(count), 32'(q.size()));
            check("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) check("m_out_data", 32'(out_data), 32'(q[0]));
            check("m_overrun", 32'(overrun), 32'(m_ovr));
            check("m_err_count", 32'(err_count), ERR_EN ? 32'(m_err) : 32'd0);
        end
    end

    task automatic send_frame(input logic [7:0] d, input bit e, input int dly, input int blen);
        int n;
        n = 0;
        do begin
            @(negedge clk_baud_16x);
            n++;
        end while (!recv_read && n < 64);
        check("arm_wait", 32'(recv_read), 32'd1);
        repeat (dly) @(negedge clk_baud_16x);
        recv_busy = 1'b1;
        repeat (blen) @(negedge clk_baud_16x);
        recv_busy = 1'b0;
        recv_data = d;
        recv_error = e;
    endtask

    task automatic wait_write();
        repeat (2) @(posedge clk_baud_16x);
        #1;
    endtask

    task automatic pop_one();
        @(negedge clk_baud_16x);
        out_ready = 1'b1;
        @(negedge clk_baud_16x);
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_tail [4];
        exp_tail = '{8'h22, 8'h33, 8'h44, 8'h55};

        // Reset and idle arming
        repeat (3) @(negedge clk_baud_16x);
        check("rst_recv_read", 32'(recv_read), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        @(posedge clk_baud_16x);
        #1;
        check("read_first", 32'(recv_read), 32'd1);
        repeat (5) @(posedge clk_baud_16x);
        #1;
        check("read_held", 32'(recv_read), 32'd1);

        // Two good words, then one pop
        send_frame(8'hA5, 1'b0, 1, 3);
        send_frame(8'h3C, 1'b0, 0, 5);
        wait_write();
        check("two_count", 32'(count), 32'd2);
        check("two_head", 32'(out_data), 32'hA5);
        pop_one();
        check("pop_head", 32'(out_data), 32'h3C);
        check("pop_count", 32'(count), 32'd1);

        // Errored frame is discarded and the receiver re-armed two clocks after busy falls
        send_frame(8'hFF, 1'b1, 2, 4);
        @(posedge clk_baud_16x);
        #1;
        check("rearm_gap", 32'(recv_read), 32'd0);
        @(posedge clk_baud_16x);
        #1;
        check("rearm", 32'(recv_read), 32'd1);
        check("err_count_unch", 32'(count), 32'd1);
        check("err_count_val", 32'(err_count), ERR_EN ? 32'd1 : 32'd0);

        // Overrun on the fifth word into a depth-4 FIFO
        pop_one();
        check("drain_count", 32'(count), 32'd0);
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 0, 2);
        wait_write();
        check("ovr_count", 32'(count), 32'd4);
        check("ovr_flag", 32'(overrun), 32'd1);
        @(negedge clk_baud_16x);
        overrun_clear = 1'b1;
        @(negedge clk_baud_16x);
        overrun_clear = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            check("ovr_contents", 32'(out_data), 32'(i));
            pop_one();
        end
        check("ovr_empty", 32'(count), 32'd0);

        // Full FIFO with a pop coinciding with the push
        send_frame(8'h11, 1'b0, 0, 2);
        send_frame(8'h22, 1'b0, 0, 2);
        send_frame(8'h33, 1'b0, 0, 2);
        send_frame(8'h44, 1'b0, 0, 2);
        wait_write();
        check("full_count", 32'(count), 32'd4);
        send_frame(8'h55, 1'b0, 0, 2);
        @(negedge clk_baud_16x);
        out_ready = 1'b1;
        @(negedge clk_baud_16x);
        out_ready = 1'b0;
        check("fullpop_count", 32'(count), 32'd4);
        check("fullpop_ovr", 32'(overrun), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("fullpop_data", 32'(out_data), 32'(exp_tail[i]));
            pop_one();
        end

        // Reset while the FSM waits on a frame with three words buffered
        send_frame(8'hA1, 1'b0, 0, 2);
        send_frame(8'hB2, 1'b0, 0, 2);
        send_frame(8'hC3, 1'b0, 0, 2);
        wait_write();
        check("pre_rst_count", 32'(count), 32'd3);
        @(negedge clk_baud_16x);
        check("pre_rst_armed", 32'(recv_read), 32'd1);
        recv_busy = 1'b1;
        repeat (3) @(negedge clk_baud_16x);
        reset_n = 1'b0;
        recv_busy = 1'b0;
        @(negedge clk_baud_16x);
        reset_n = 1'b1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_read", 32'(recv_read), 32'd0);
        @(posedge clk_baud_16x);
        #1;
        check("mid_rst_rearm", 32'(recv_read), 32'd1);

        // Randomized traffic: slow consumer first to provoke overruns, then a fast one
        rand_on = 1'b1;
        fork
            begin
                for (int k = 0; k < 80; k++) begin
                    send_frame(8'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                               $urandom_range(1, 6));
                    frames_sent++;
                end
                repeat (3) @(negedge clk_baud_16x);
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(negedge clk_baud_16x);
                    out_ready = (frames_sent < 40) ? ($urandom_range(0, 7) == 0)
                                                   : ($urandom_range(0, 3) != 0);
                    overrun_clear = ($urandom_range(0, 11) == 0);
                end
            end
        join
        out_ready = 1'b0;
        overrun_clear = 1'b0;

        // Enough errored frames to reach counter saturation
        for (int k = 0; k < 260; k++) send_frame(8'($urandom), 1'b1, 0, 1);
        wait_write();
        check("err_sat", 32'(err_count), ERR_EN ? 32'd255 : 32'd0);

        repeat (4) @(negedge clk_baud_16x);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
